// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: opcode decode, XLEN sign extension and a
// 2-entry skid buffer with valid/ready on both sides, plus an illegal-opcode counter.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_inst,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal,
    input  logic             i_flush,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_illegal_cnt
);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    occ_t              occ;
    entry_t            head;
    entry_t            tail;
    entry_t            new_ent;
    logic signed [31:0] imm32;
    logic [2:0]        fmt;
    logic              push;
    logic              pop;

    always_comb begin
        imm32 = '0;
        fmt   = 3'd7;
        unique case (i_inst[6:0])
            7'b1100111, 7'b0000011, 7'b0010011: begin
                imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
                fmt   = 3'd0;
            end
            7'b0100011: begin
                imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                fmt   = 3'd1;
            end
            7'b1100011: begin
                imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                         i_inst[11:8], 1'b0};
                fmt   = 3'd2;
            end
            7'b0110111, 7'b0010111: begin
                imm32 = {i_inst[31:12], 12'b0};
                fmt   = 3'd3;
            end
            7'b1101111: begin
                imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                         i_inst[30:21], 1'b0};
                fmt   = 3'd4;
            end
            7'b0110011: fmt = 3'd5;
            7'b1110011: begin
                imm32 = {27'b0, i_inst[19:15]};
                fmt   = 3'd6;
            end
            default: fmt = 3'd7;
        endcase
    end

    // Every 32-bit immediate already carries its sign in bit 31 (CSR zimm has 0 there),
    // so a signed size cast gives the XLEN extension for all formats.
    always_comb begin
        new_ent.inst    = i_inst;
        new_ent.imm     = XLEN'(imm32);
        new_ent.fmt     = fmt;
        new_ent.illegal = (fmt == 3'd7);
    end

    assign o_ready = (occ != OCC_FULL);
    assign o_valid = (occ != OCC_EMPTY);
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    // Head register is zeroed whenever it holds nothing, so outputs read 0 when empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            tail <= '0;
        end else if (i_flush) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            unique case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head <= new_ent;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head <= new_ent;
                    end else if (push) begin
                        tail <= new_ent;
                        occ  <= OCC_FULL;
                    end else if (pop) begin
                        head <= '0;
                        occ  <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head <= tail;
                        tail <= '0;
                        occ  <= OCC_ONE;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_illegal_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_illegal_cnt <= '0;
        end else if (push && new_ent.illegal && (o_illegal_cnt != '1)) begin
            o_illegal_cnt <= o_illegal_cnt + 1'b1;
        end
    end

    assign o_inst    = head.inst;
    assign o_imm     = head.imm;
    assign o_fmt     = head.fmt;
    assign o_illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (RV32, RV64, 2-bit counter)
// share one stimulus stream; expected values are hand-computed.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [31:0] inst;
    logic        flush;
    logic        cnt_clr;

    logic        a_ready, a_valid, a_illegal;
    logic [31:0] a_inst, a_imm;
    logic [2:0]  a_fmt;
    logic [7:0]  a_cnt;

    logic        b_ready, b_valid, b_illegal;
    logic [31:0] b_inst;
    logic [63:0] b_imm;
    logic [2:0]  b_fmt;
    logic [7:0]  b_cnt;

    logic        c_ready, c_valid, c_illegal;
    logic [31:0] c_inst, c_imm;
    logic [2:0]  c_fmt;
    logic [1:0]  c_cnt;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(a_ready),
        .i_inst(inst), .o_valid(a_valid), .i_ready(ready), .o_inst(a_inst),
        .o_imm(a_imm), .o_fmt(a_fmt), .o_illegal(a_illegal), .i_flush(flush),
        .i_cnt_clr(cnt_clr), .o_illegal_cnt(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(b_ready),
        .i_inst(inst), .o_valid(b_valid), .i_ready(ready), .o_inst(b_inst),
        .o_imm(b_imm), .o_fmt(b_fmt), .o_illegal(b_illegal), .i_flush(flush),
        .i_cnt_clr(cnt_clr), .o_illegal_cnt(b_cnt)
    );

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(c_ready),
        .i_inst(inst), .o_valid(c_valid), .i_ready(ready), .o_inst(c_inst),
        .o_imm(c_imm), .o_fmt(c_fmt), .o_illegal(c_illegal), .i_flush(flush),
        .i_cnt_clr(cnt_clr), .o_illegal_cnt(c_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 11;
    logic [31:0] v_inst [NV] = '{
        32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h800000B7, 32'h000FD073,
        32'h001000EF, 32'h002081B3, 32'h12345017, 32'h00412083, 32'h800080E7,
        32'h0000006F
    };
    logic [63:0] v_imm [NV] = '{
        64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
        64'hFFFFFFFF80000000, 64'h000000000000001F, 64'h0000000000000800,
        64'h0000000000000000, 64'h0000000012345000, 64'h0000000000000004,
        64'hFFFFFFFFFFFFF800, 64'h0000000000000000
    };
    logic [2:0] v_fmt [NV] = '{
        3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd4, 3'd5, 3'd3, 3'd0, 3'd0, 3'd4
    };

    initial begin
        rst_n = 1'b0; valid = 1'b0; ready = 1'b1; inst = '0; flush = 1'b0; cnt_clr = 1'b0;
        #23;
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_imm64", b_imm, 64'd0);
        check("rst_cnt", 64'(a_cnt), 64'd0);
        rst_n = 1'b1;
        step();
        check("rel_ready", 64'(a_ready), 64'd1);
        check("rel_valid", 64'(a_valid), 64'd0);

        // back-to-back stream with downstream always ready
        for (int i = 0; i < NV; i++) begin
            valid = 1'b1;
            inst  = v_inst[i];
            step();
            check($sformatf("v%0d_valid", i), 64'(a_valid), 64'd1);
            check($sformatf("v%0d_inst", i), 64'(a_inst), 64'(v_inst[i]));
            check($sformatf("v%0d_imm32", i), 64'(a_imm), {32'd0, v_imm[i][31:0]});
            check($sformatf("v%0d_imm64", i), b_imm, v_imm[i]);
            check($sformatf("v%0d_fmt", i), 64'(a_fmt), 64'(v_fmt[i]));
            check($sformatf("v%0d_ill", i), 64'(a_illegal), 64'd0);
        end
        valid = 1'b0;
        step();
        check("drain_valid", 64'(a_valid), 64'd0);
        check("drain_imm", 64'(a_imm), 64'd0);
        check("drain_cnt", 64'(a_cnt), 64'd0);

        // backpressure
        ready = 1'b0; valid = 1'b1; inst = 32'h00100093;
        step();
        check("bp1_ready", 64'(a_ready), 64'd1);
        check("bp1_head", 64'(a_inst), 64'h00100093);
        inst = 32'h00200113;
        step();
        check("bp2_ready", 64'(a_ready), 64'd0);
        inst = 32'h00300193;
        step();
        check("bp3_ready", 64'(a_ready), 64'd0);
        check("bp3_head", 64'(a_inst), 64'h00100093);
        ready = 1'b1;
        step();
        check("pop1_head", 64'(a_inst), 64'h00200113);
        check("pop1_ready", 64'(a_ready), 64'd1);
        check("pop1_imm", 64'(a_imm), 64'd2);
        step();
        check("pop2_head", 64'(a_inst), 64'h00300193);
        check("pop2_valid", 64'(a_valid), 64'd1);
        valid = 1'b0;
        step();
        check("pop3_valid", 64'(a_valid), 64'd0);

        // illegal opcodes, flush and counter clear
        valid = 1'b1; inst = 32'hFFFFFFFF;
        step();
        check("ill1_flag", 64'(a_illegal), 64'd1);
        check("ill1_imm", b_imm, 64'd0);
        check("ill1_fmt", 64'(a_fmt), 64'd7);
        check("ill1_cnt", 64'(a_cnt), 64'd1);
        step();
        check("ill2_flag", 64'(a_illegal), 64'd1);
        check("ill2_cnt", 64'(a_cnt), 64'd2);
        flush = 1'b1;
        step();
        check("flush_valid", 64'(a_valid), 64'd0);
        check("flush_ready", 64'(a_ready), 64'd1);
        check("flush_inst", 64'(a_inst), 64'd0);
        check("flush_cnt", 64'(a_cnt), 64'd3);
        check("flush_cnt_sat", 64'(c_cnt), 64'd3);
        flush = 1'b0; cnt_clr = 1'b1;
        step();
        check("clr_cnt", 64'(a_cnt), 64'd0);
        check("clr_cnt_sat", 64'(c_cnt), 64'd0);
        check("clr_push_valid", 64'(a_valid), 64'd1);
        cnt_clr = 1'b0;

        // saturation on the 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("sat%0d_cnt8", k), 64'(a_cnt), 64'(k));
            check($sformatf("sat%0d_cnt2", k), 64'(c_cnt), 64'((k > 3) ? 3 : k));
        end

        // reset with two entries buffered
        ready = 1'b0; inst = 32'h00412083;
        step();
        valid = 1'b0;
        check("full_ready", 64'(a_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 64'(a_valid), 64'd0);
        check("mrst_inst", 64'(a_inst), 64'd0);
        check("mrst_imm64", b_imm, 64'd0);
        check("mrst_fmt", 64'(a_fmt), 64'd0);
        check("mrst_ill", 64'(a_illegal), 64'd0);
        check("mrst_cnt", 64'(a_cnt), 64'd0);
        check("mrst_cnt_sat", 64'(c_cnt), 64'd0);
        #3;
        rst_n = 1'b1;
        step();
        check("mrel_ready", 64'(a_ready), 64'd1);
        check("mrel_valid", 64'(a_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage of the RV32I/RV64I datapath. It extracts the opcode itself from the instruction word. It produces the sign-extended immediate at XLEN width, a format code, and an illegal-opcode flag. Results pass through a 2-entry skid buffer with valid/ready handshakes on both sides, and the block keeps a saturating count of illegal instructions for debug.

Parameters:
XLEN, 32, datapath/immediate width; legal values 32 or 64
CNT_W, 8, width of the illegal-instruction counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  block can accept an instruction this cycle
i_inst  in  32  instruction word; opcode = i_inst[6:0]
o_valid  out  1  head entry valid
i_ready  in  1  downstream accepts head entry
o_inst  out  32  instruction of head entry, passthrough
o_imm  out  XLEN  extended immediate of head entry
o_fmt  out  3  format code of head entry
o_illegal  out  1  head entry has unsupported opcode
i_flush  in  1  synchronous discard of all buffered entries
i_cnt_clr  in  1  synchronous clear of illegal counter
o_illegal_cnt  out  CNT_W  saturating illegal-instruction count

Behaviour:
- Reset (async, i_rst_n=0): buffer empty; o_valid=0; o_inst/o_imm/o_fmt/o_illegal=0; o_illegal_cnt=0; o_ready=1 once reset is released.
- Push = i_valid & o_ready. Pop = o_valid & i_ready. o_ready = (occupancy < 2), driven from state only, never from i_valid or i_ready.
- Latency: an instruction pushed into an empty buffer appears with o_valid=1 on the next cycle. Entries are strictly FIFO.
- Simultaneous push and pop at occupancy 1: occupancy stays 1 and the new entry becomes head next cycle. At occupancy 2 no push is possible. Pop at occupancy 2 raises o_ready next cycle.
- Immediate is computed combinationally at push time and stored; all outputs come from registers.
- o_fmt / o_imm by opcode (bit 31 is the sign bit, extended to XLEN):
  - 0: I (JALR 1100111, LOAD 0000011, ALUI 0010011): sext(inst[31:20])
  - 1: S (0100011): sext({inst[31:25],inst[11:7]})
  - 2: B (1100011): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
  - 3: U (LUI 0110111, AUIPC 0010111): sext({inst[31:12],12'b0})
  - 4: J (1101111): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
  - 5: R (0110011): imm=0
  - 6: CSR (SYSTEM 1110011): zero-extended inst[19:15]
  - 7: illegal (any other opcode): imm=0, o_illegal=1
- Empty buffer: o_valid=0 and o_inst/o_imm/o_fmt/o_illegal read 0.
- i_flush=1: occupancy becomes 0 next cycle and o_valid=0. A push in the same cycle is discarded. A pop in the same cycle still completes on the downstream side. o_ready=1 next cycle.
- Illegal counter: increments by 1 on each push with format 7, whether or not i_flush is asserted that cycle. It saturates at 2^CNT_W-1. i_cnt_clr has priority over increment.
- Reset asserted mid-operation: immediate return to reset values; in-flight entries are lost.
- Unknown XLEN values are unsupported; elaboration fails if XLEN is not 32 or 64.

Test Plan:
1. XLEN=32, push 0xFFF00093 (addi x1,x0,-1) with i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_fmt=0, o_illegal=0.
2. Push 0xFE112E23 (sw x1,-4(x2)), then 0xFE000CE3 (beq x0,x0,-8) back-to-back -> o_imm 0xFFFFFFFC fmt 1, then 0xFFFFFFF8 fmt 2, on consecutive cycles.
3. XLEN=64, push 0x800000B7 (lui x1,0x80000) -> o_imm=0xFFFFFFFF80000000, o_fmt=3. Push 0x000FD073 (csrrwi, zimm=31) -> o_imm=0x1F, o_fmt=6.
4. i_ready=0, i_valid=1 for 3 cycles with distinct instructions -> o_ready falls after 2 pushes. Release i_ready -> entries pop in push order and the third is accepted one cycle after the first pop.
5. Push 0xFFFFFFFF three times, the last with i_flush=1 -> o_illegal=1 with o_imm=0 on delivered entries, o_illegal_cnt=3, o_valid=0 after flush. Pulse i_cnt_clr together with a further illegal push -> count=0.
6. CNT_W=2, push 5 illegal instructions -> o_illegal_cnt saturates at 3. Assert i_rst_n=0 with 2 entries buffered -> all outputs 0 immediately and o_ready=1 after release.
